// File: rtl/uart_rx_16x.sv
// UART receiver driven by a 16x oversampling tick: start, DATA_BITS data bits (LSB first), stop bit.
// Define UART_RX_PARITY_EN to add an even parity bit between data and stop, plus a parity_error flag.
module uart_rx_16x #(
    parameter int DATA_BITS       = 8,
    parameter int SAMPLES_PER_BIT = 16
) (
    input  logic                 clock50M,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy
);

    localparam int CW = $clog2(SAMPLES_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SAMPLES_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_meta;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_acc;
`endif

    always_ff @(posedge clock50M or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Flag clears from rd_en come first so that a set later in the same cycle wins.
    always_ff @(posedge clock50M or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            data_out      <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
            par_acc       <= 1'b0;
`endif
        end else begin
            if (rd_en) begin
                data_ready    <= 1'b0;
                framing_error <= 1'b0;
                overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_error  <= 1'b0;
`endif
            end
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == HALF_CNT) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                                par_acc <= 1'b0;
`endif
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == FULL_CNT) begin
                            cnt       <= '0;
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            bit_idx   <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                            par_acc   <= par_acc ^ rx_s;
                            if (bit_idx == LAST_BIT) state <= PARITY;
`else
                            if (bit_idx == LAST_BIT) state <= STOP;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt == FULL_CNT) begin
                            cnt   <= '0;
                            state <= STOP;
                            if (par_acc ^ rx_s) parity_error <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    // Returning at mid stop bit leaves half a bit to catch the next start edge.
                    STOP: begin
                        if (cnt == FULL_CNT) begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_s) begin
                                framing_error <= 1'b1;
                            end else if (data_ready && !rd_en) begin
                                overrun_error <= 1'b1;
                            end else begin
                                data_out   <= shift_reg;
                                data_ready <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Self-checking bench for uart_rx_16x: 115200 baud ticks (every 27 clocks), scoreboard of expected words.
// Build with UART_RX_PARITY_EN to also exercise the parity bit and parity_error.
module tb_uart_rx_16x;

    localparam int DATA_BITS = 8;
    localparam int SPB       = 16;
    localparam int TICK_DIV  = 27;
    localparam int BIT_CLKS  = SPB * TICK_DIV;
    localparam int LAT_MIN   = 4104;
    localparam int LAT_MAX   = 4140;

    logic                 clock50M = 1'b0;
    logic                 reset    = 1'b1;
    logic                 tick     = 1'b0;
    logic                 rx       = 1'b1;
    logic                 rd_en    = 1'b0;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_ready;
    logic                 framing_error;
    logic                 overrun_error;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_error;
`endif

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_16x #(.DATA_BITS(DATA_BITS), .SAMPLES_PER_BIT(SPB)) dut (
        .clock50M      (clock50M),
        .reset         (reset),
        .tick          (tick),
        .rx            (rx),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
`ifdef UART_RX_PARITY_EN
        .parity_error  (parity_error),
`endif
        .busy          (busy)
    );

    always #10 clock50M = ~clock50M;

    always @(negedge clock50M) begin
        if (tick_cnt == TICK_DIV - 1) begin
            tick_cnt = 0;
            tick     = 1'b1;
        end else begin
            tick_cnt = tick_cnt + 1;
            tick     = 1'b0;
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clock50M);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
        send_bit(par_bit);
        send_bit(1'b1);
    endtask
`endif

    // Leaves the caller on the negedge right after a tick edge, so frame timing is repeatable.
    task automatic align_tick;
        do @(posedge clock50M); while (tick !== 1'b1);
        @(negedge clock50M);
    endtask

    task automatic do_read;
        @(negedge clock50M);
        rd_en = 1'b1;
        @(negedge clock50M);
        rd_en = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 22 * BIT_CLKS; i++) begin
            if (data_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock50M);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock50M);
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_ready: got %b expected 0", data_ready); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_framing: got %b expected 0", framing_error); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
`ifdef UART_RX_PARITY_EN
        checks++; if (parity_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity: got %b expected 0", parity_error); end
`endif
        reset = 1'b0;
        repeat (5) @(negedge clock50M);
    endtask

    task automatic test_basic;
        int lat;
        logic [7:0] exp;
        exp_q.push_back(8'hA5);
        align_tick;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (data_ready !== 1'b1 && lat < 6000) begin
                    @(negedge clock50M);
                    lat++;
                end
            end
        join
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL basic_latency: got %0d clocks expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready: got %b expected 1", data_ready); end
        checks++; if (data_out !== exp) begin errors++; $display("[TB] FAIL basic_data: got %h expected %h", data_out, exp); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("[TB] FAIL basic_framing: got %b expected 0", framing_error); end
        do_read;
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_read_clear: got %b expected 0", data_ready); end
    endtask

    task automatic test_glitch;
        align_tick;
        rx = 1'b0;
        repeat (3 * TICK_DIV) @(negedge clock50M);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_rise: got %b expected 1", busy); end
        repeat (2 * TICK_DIV) @(negedge clock50M);
        rx = 1'b1;
        repeat (20 * TICK_DIV) @(negedge clock50M);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_fall: got %b expected 0", busy); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL glitch_ready: got %b expected 0", data_ready); end
        checks++; if ({framing_error, overrun_error} !== 2'b00) begin errors++; $display("[TB] FAIL glitch_flags: got %b%b expected 00", framing_error, overrun_error); end
    endtask

    task automatic test_framing;
        send_frame(8'h3C, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clock50M);
        checks++; if (framing_error !== 1'b1) begin errors++; $display("[TB] FAIL framing_set: got %b expected 1", framing_error); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL framing_ready: got %b expected 0", data_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL framing_busy: got %b expected 0", busy); end
        do_read;
        checks++; if (framing_error !== 1'b0) begin errors++; $display("[TB] FAIL framing_clear: got %b expected 1->0", framing_error); end
    endtask

    task automatic test_overrun;
        int lat;
        bit seen;
        logic [7:0] exp;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        repeat (BIT_CLKS) @(negedge clock50M);
        align_tick;
        fork
            send_frame(8'h22, 1'b1);
            begin
                lat = 0;
                seen = 1'b0;
                while (lat < 6000) begin
                    @(negedge clock50M);
                    lat++;
                    if (busy === 1'b1) seen = 1'b1;
                    else if (seen) break;
                end
            end
        join
        repeat (BIT_CLKS) @(negedge clock50M);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("[TB] FAIL overrun_frame_end: got %0d clocks expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        checks++; if (data_out !== exp) begin errors++; $display("[TB] FAIL overrun_data: got %h expected %h", data_out, exp); end
        checks++; if (overrun_error !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b expected 1", overrun_error); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL overrun_ready: got %b expected 1", data_ready); end
        do_read;
        checks++; if ({data_ready, overrun_error} !== 2'b00) begin errors++; $display("[TB] FAIL overrun_clear: got %b%b expected 00", data_ready, overrun_error); end

        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        repeat (BIT_CLKS) @(negedge clock50M);
        align_tick;
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (lat - 1) @(negedge clock50M);
                rd_en = 1'b1;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++; if (data_out !== exp) begin errors++; $display("[TB] FAIL overrun_read_old: got %h expected %h", data_out, exp); end
                @(negedge clock50M);
                rd_en = 1'b0;
            end
        join
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (data_out !== exp) begin errors++; $display("[TB] FAIL same_cycle_data: got %h expected %h", data_out, exp); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_ready: got %b expected 1", data_ready); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_overrun: got %b expected 0", overrun_error); end
        do_read;
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [7:0] exp;
        logic [7:0] partial;
        partial = 8'h96;
        align_tick;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(partial[i]);
        rx = partial[3];
        repeat (BIT_CLKS / 2) @(negedge clock50M);
        reset = 1'b1;
        repeat (3) @(negedge clock50M);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock50M);
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_discard: got %b expected 0", data_ready); end
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_ready(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL midreset_timeout: got data_ready %b expected 1", data_ready); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (data_out !== exp) begin errors++; $display("[TB] FAIL midreset_data: got %h expected %h", data_out, exp); end
        checks++; if ({framing_error, overrun_error} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_flags: got %b%b expected 00", framing_error, overrun_error); end
        do_read;
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [7:0] exp;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        fork
            begin
                send_frame(8'h5A, 1'b1);
                send_frame(8'hC3, 1'b1);
            end
            for (int n = 0; n < 2; n++) begin
                wait_ready(ok);
                checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout%0d: got data_ready %b expected 1", n, data_ready); end
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++; if (data_out !== exp) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", n, data_out, exp); end
                do_read;
            end
        join
        repeat (BIT_CLKS) @(negedge clock50M);
        checks++; if (overrun_error !== 1'b0 || framing_error !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flags: got %b%b expected 00", framing_error, overrun_error); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_queue: got %0d left expected 0", exp_q.size()); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        logic [7:0] exp;
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (data_out !== exp) begin errors++; $display("[TB] FAIL parity_good_data: got %h expected %h", data_out, exp); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("[TB] FAIL parity_good_flag: got %b expected 0", parity_error); end
        do_read;
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (parity_error !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad_flag: got %b expected 1", parity_error); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad_ready: got %b expected 1", data_ready); end
        checks++; if (data_out !== exp) begin errors++; $display("[TB] FAIL parity_bad_data: got %h expected %h", data_out, exp); end
        do_read;
        checks++; if (parity_error !== 1'b0) begin errors++; $display("[TB] FAIL parity_clear: got %b expected 0", parity_error); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_framing;
        test_overrun;
        test_reset_mid;
        test_back_to_back;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
